// File: rtl/cpu_pkg.sv
// Shared definitions for the internal-data-bus transfer sequencer:
// register indices, bus width and FSM state encoding.
package cpu_pkg;

  localparam int W    = 8;
  localparam int NREG = 4;
  localparam int IW   = 2;

  localparam logic [IW-1:0] REG_A  = 2'd0;
  localparam logic [IW-1:0] REG_X  = 2'd1;
  localparam logic [IW-1:0] REG_Y  = 2'd2;
  localparam logic [IW-1:0] REG_SP = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_LATCH = 3'd2,
    ST_FIN   = 3'd3,
    ST_REJ   = 3'd4
  } state_t;

  // True when a register index addresses an attached register.
  function automatic logic idx_ok(input logic [IW-1:0] idx, input int nreg);
    return (int'(idx) < nreg);
  endfunction

endpackage

// File: rtl/bus_xfer_seq_if.sv
// Request/strobe/flag bundle between decode, the register file and the
// transfer sequencer.
interface bus_xfer_seq_if #(
  parameter int W    = cpu_pkg::W,
  parameter int NREG = cpu_pkg::NREG,
  parameter int IW   = cpu_pkg::IW
);
  logic            start;
  logic [IW-1:0]   src;
  logic [IW-1:0]   dst;
  logic [W-1:0]    bus_in;
  logic [NREG-1:0] bus_enable;
  logic [NREG-1:0] load;
  logic            busy;
  logic            done;
  logic            err;
  logic            flag_upd;
  logic            flag_n;
  logic            flag_z;

  modport master (
    output start, src, dst, bus_in,
    input  bus_enable, load, busy, done, err, flag_upd, flag_n, flag_z
  );

  modport slave (
    input  start, src, dst, bus_in,
    output bus_enable, load, busy, done, err, flag_upd, flag_n, flag_z
  );
endinterface

// File: rtl/onehot_dec.sv
// Index to one-hot decoder with a global enable; all outputs 0 when disabled.
module onehot_dec #(
  parameter int NREG = cpu_pkg::NREG,
  parameter int IW   = cpu_pkg::IW
) (
  input  logic            en_i,
  input  logic [IW-1:0]   idx_i,
  output logic [NREG-1:0] onehot_o
);

  for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
    assign onehot_o[gi] = en_i && (idx_i == IW'(gi));
  end

endmodule

// File: rtl/bus_xfer_seq.sv
// Register-transfer sequencer: source output-enable, then destination load,
// with N/Z capture of the transferred value for the status register.
module bus_xfer_seq #(
  parameter int W        = cpu_pkg::W,
  parameter int NREG     = cpu_pkg::NREG,
  parameter int SP_INDEX = int'(cpu_pkg::REG_SP)
) (
  input logic            clk_i,
  input logic            rst_n_i,
  bus_xfer_seq_if.slave  bus
);
  import cpu_pkg::*;

  state_t          state_q, state_d;
  logic [IW-1:0]   src_q, dst_q;
  logic [W-1:0]    value_q;
  logic            cap_valid_q;

  logic accept, capture, be_en, ld_en;
  logic busy, done, err, flag_upd;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      value_q     <= '0;
      cap_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        src_q <= bus.src;
        dst_q <= bus.dst;
      end
      if (capture) begin
        value_q     <= bus.bus_in;
        cap_valid_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    capture  = 1'b0;
    be_en    = 1'b0;
    ld_en    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    flag_upd = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if ((bus.src == bus.dst) || !idx_ok(bus.src, NREG) || !idx_ok(bus.dst, NREG)) begin
            state_d = ST_REJ;
          end else begin
            accept  = 1'b1;
            state_d = ST_DRIVE;
          end
        end
      end
      ST_DRIVE: begin
        be_en   = 1'b1;
        busy    = 1'b1;
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        be_en   = 1'b1;
        ld_en   = 1'b1;
        busy    = 1'b1;
        capture = 1'b1;
        state_d = ST_FIN;
      end
      ST_FIN: begin
        busy     = 1'b1;
        done     = 1'b1;
        // Stack-pointer loads (TXS) do not touch the status flags.
        flag_upd = (int'(dst_q) != SP_INDEX);
        state_d  = ST_IDLE;
      end
      ST_REJ: begin
        err     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  onehot_dec #(.NREG(NREG), .IW(IW)) u_be_dec (
    .en_i     (be_en),
    .idx_i    (src_q),
    .onehot_o (bus.bus_enable)
  );

  onehot_dec #(.NREG(NREG), .IW(IW)) u_ld_dec (
    .en_i     (ld_en),
    .idx_i    (dst_q),
    .onehot_o (bus.load)
  );

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.err      = err;
  assign bus.flag_upd = flag_upd;
  // Z is qualified so that the reset value (nothing captured yet) reads 0.
  assign bus.flag_n   = value_q[W-1];
  assign bus.flag_z   = cap_valid_q && (value_q == '0);

endmodule

// File: tb/tb_bus_xfer_seq.sv
// Directed bench for bus_xfer_seq: reset, TAX, TXS, back-to-back, reject,
// and START-while-busy cases with hand-computed expectations.
module tb_bus_xfer_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   ld_cnt;
  int   done_cnt;

  bus_xfer_seq_if #(.W(8), .NREG(4), .IW(2)) bif ();

  bus_xfer_seq #(.W(8), .NREG(4), .SP_INDEX(3)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bif.start  = 1'b0;
    bif.src    = 2'd0;
    bif.dst    = 2'd0;
    bif.bus_in = 8'h00;

    // Reset state
    tick(); tick();
    chk("rst_be",   32'(bif.bus_enable), 32'h0);
    chk("rst_ld",   32'(bif.load),       32'h0);
    chk("rst_busy", 32'(bif.busy),       32'h0);
    chk("rst_done", 32'(bif.done),       32'h0);
    chk("rst_err",  32'(bif.err),        32'h0);
    chk("rst_fn",   32'(bif.flag_n),     32'h0);
    chk("rst_fz",   32'(bif.flag_z),     32'h0);
    rst_n = 1'b1;
    $display("step reset released");

    // 1. asynchronous reset mid-DRIVE
    bif.start = 1'b1; bif.src = 2'd0; bif.dst = 2'd1; bif.bus_in = 8'h55;
    tick();
    bif.start = 1'b0;
    chk("t1_drive_be",   32'(bif.bus_enable), 32'h1);
    chk("t1_drive_busy", 32'(bif.busy),       32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_be",   32'(bif.bus_enable), 32'h0);
    chk("t1_async_ld",   32'(bif.load),       32'h0);
    chk("t1_async_busy", 32'(bif.busy),       32'h0);
    chk("t1_async_done", 32'(bif.done),       32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t1_idle_busy", 32'(bif.busy),       32'h0);
    chk("t1_idle_be",   32'(bif.bus_enable), 32'h0);
    chk("t1_idle_ld",   32'(bif.load),       32'h0);
    chk("t1_idle_fz",   32'(bif.flag_z),     32'h0);
    $display("step 1 async reset mid-transfer");

    // 2. TAX, value AA
    bif.start = 1'b1; bif.src = 2'd0; bif.dst = 2'd1; bif.bus_in = 8'hAA;
    tick();
    bif.start = 1'b0;
    chk("t2_c1_be",   32'(bif.bus_enable), 32'h1);
    chk("t2_c1_ld",   32'(bif.load),       32'h0);
    chk("t2_c1_busy", 32'(bif.busy),       32'h1);
    tick();
    chk("t2_c2_be",   32'(bif.bus_enable), 32'h1);
    chk("t2_c2_ld",   32'(bif.load),       32'h2);
    chk("t2_c2_done", 32'(bif.done),       32'h0);
    tick();
    chk("t2_fin_be",   32'(bif.bus_enable), 32'h0);
    chk("t2_fin_ld",   32'(bif.load),       32'h0);
    chk("t2_fin_done", 32'(bif.done),       32'h1);
    chk("t2_fin_upd",  32'(bif.flag_upd),   32'h1);
    chk("t2_fin_busy", 32'(bif.busy),       32'h1);
    chk("t2_fn",       32'(bif.flag_n),     32'h1);
    chk("t2_fz",       32'(bif.flag_z),     32'h0);
    tick();
    chk("t2_idle_done", 32'(bif.done), 32'h0);
    chk("t2_idle_busy", 32'(bif.busy), 32'h0);
    $display("step 2 TAX AA");

    // 3. TXS, value 00
    bif.start = 1'b1; bif.src = 2'd1; bif.dst = 2'd3; bif.bus_in = 8'h00;
    tick();
    bif.start = 1'b0;
    chk("t3_c1_be", 32'(bif.bus_enable), 32'h2);
    tick();
    chk("t3_c2_be", 32'(bif.bus_enable), 32'h2);
    chk("t3_c2_ld", 32'(bif.load),       32'h8);
    tick();
    chk("t3_fin_done", 32'(bif.done),     32'h1);
    chk("t3_fin_upd",  32'(bif.flag_upd), 32'h0);
    chk("t3_fz",       32'(bif.flag_z),   32'h1);
    chk("t3_fn",       32'(bif.flag_n),   32'h0);
    tick();
    $display("step 3 TXS 00");

    // 4. TYA 7F then TAY 00 with START held
    bif.start = 1'b1; bif.src = 2'd2; bif.dst = 2'd0; bif.bus_in = 8'h7F;
    tick();
    chk("t4a_c1_be", 32'(bif.bus_enable), 32'h4);
    bif.src = 2'd0; bif.dst = 2'd2;
    tick();
    chk("t4a_c2_ld", 32'(bif.load), 32'h1);
    chk("t4a_c2_be", 32'(bif.bus_enable), 32'h4);
    tick();
    chk("t4a_fin_done", 32'(bif.done),     32'h1);
    chk("t4a_fin_upd",  32'(bif.flag_upd), 32'h1);
    chk("t4a_fn",       32'(bif.flag_n),   32'h0);
    chk("t4a_fz",       32'(bif.flag_z),   32'h0);
    bif.bus_in = 8'h00;
    tick();
    chk("t4_gap_busy", 32'(bif.busy),       32'h0);
    chk("t4_gap_be",   32'(bif.bus_enable), 32'h0);
    tick();
    chk("t4b_c1_be",   32'(bif.bus_enable), 32'h1);
    chk("t4b_c1_busy", 32'(bif.busy),       32'h1);
    bif.start = 1'b0;
    tick();
    chk("t4b_c2_ld", 32'(bif.load), 32'h4);
    tick();
    chk("t4b_fin_done", 32'(bif.done),   32'h1);
    chk("t4b_fz",       32'(bif.flag_z), 32'h1);
    chk("t4b_fn",       32'(bif.flag_n), 32'h0);
    tick();
    tick();
    chk("t4_end_busy", 32'(bif.busy), 32'h0);
    chk("t4_end_be",   32'(bif.bus_enable), 32'h0);
    $display("step 4 back-to-back TYA/TAY");

    // 5. rejected request SRC == DST
    bif.start = 1'b1; bif.src = 2'd2; bif.dst = 2'd2; bif.bus_in = 8'hFF;
    tick();
    bif.start = 1'b0;
    chk("t5_err",  32'(bif.err),        32'h1);
    chk("t5_be",   32'(bif.bus_enable), 32'h0);
    chk("t5_ld",   32'(bif.load),       32'h0);
    chk("t5_done", 32'(bif.done),       32'h0);
    chk("t5_busy", 32'(bif.busy),       32'h0);
    tick();
    chk("t5_err_clr", 32'(bif.err),    32'h0);
    tick();
    chk("t5_be2",     32'(bif.bus_enable), 32'h0);
    chk("t5_fz_keep", 32'(bif.flag_z), 32'h1);
    chk("t5_fn_keep", 32'(bif.flag_n), 32'h0);
    $display("step 5 reject SRC=DST");

    // 6. TXA with a START pulse during LATCH
    bif.start = 1'b1; bif.src = 2'd1; bif.dst = 2'd0; bif.bus_in = 8'h80;
    tick();
    bif.start = 1'b0;
    chk("t6_c1_be", 32'(bif.bus_enable), 32'h2);
    tick();
    chk("t6_c2_ld", 32'(bif.load), 32'h1);
    bif.start = 1'b1; bif.src = 2'd2; bif.dst = 2'd1;
    tick();
    bif.start = 1'b0;
    chk("t6_fin_done", 32'(bif.done),   32'h1);
    chk("t6_fn",       32'(bif.flag_n), 32'h1);
    chk("t6_fz",       32'(bif.flag_z), 32'h0);
    ld_cnt   = 0;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bif.load != 4'h0) ld_cnt++;
      if (bif.done) done_cnt++;
    end
    chk("t6_extra_ld",   32'(ld_cnt),   32'h0);
    chk("t6_extra_done", 32'(done_cnt), 32'h0);
    chk("t6_fn_keep",    32'(bif.flag_n), 32'h1);
    $display("step 6 START ignored while busy");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
